scan_chain_programmer: RTL and testbench
========================================

Name: scan_chain_programmer

Overview:
- Drives the configuration scan chain formed by the fabric's SRAM cells (connection blocks, switch blocks, LUTs).
- Load mode: accepts configuration words from the host interface, serializes them LSB-first and shifts exactly CHAIN_LENGTH bits into the chain head.
- Readback mode: shifts the chain through exactly CHAIN_LENGTH positions, returning tail bits to the host as words and recirculating them into the head, so the configuration is unchanged afterwards.
- Sits between the host/config port and the fabric's scan_in/scan_en/scan_out chain pins.

Parameters:
- CHAIN_LENGTH, 64, total number of SRAM bits in the scan chain (>=1).
- WORD_WIDTH, 8, host word width (>=2).
- CNT_W, $clog2(CHAIN_LENGTH+1), bit counter width (derived; not overridden).

Ports:
- scan_clk  in  1  sole clock; the chain is clocked by the same clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = load, 1 = readback; sampled with start.
- wr_data  in  WORD_WIDTH  load word, LSB shifted first.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  word accepted when wr_valid && wr_ready.
- rd_data  out  WORD_WIDTH  readback word; first tail bit in bit 0.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  host accepts rd_data.
- chain_scan_en  out  1  to the chain's scan_en.
- chain_scan_in  out  1  to the scan_in of the first chain element.
- chain_scan_out  in  1  from the scan_out of the last chain element.
- busy  out  1  high in LOAD, READ and DONE.
- done  out  1  one-cycle pulse on completion.
- bit_count  out  CNT_W  bits shifted in the current operation.

Behaviour:
- Reset (async, immediate): state IDLE.
  - All outputs 0: chain_scan_en, wr_ready, rd_valid, done, busy, bit_count, rd_data.
  - Internal shift/collect registers are cleared.
  - A reset mid-operation leaves the chain partially shifted; the chain must be reloaded.
- States and transitions:
  - IDLE:
    - start with mode=0 -> LOAD.
    - start with mode=1 -> READ.
    - bit_count clears on entry to LOAD or READ.
  - LOAD -> DONE in the cycle after bit_count reaches CHAIN_LENGTH.
  - READ -> DONE once bit_count == CHAIN_LENGTH and the last word has been accepted.
  - DONE: single cycle; done=1, then -> IDLE.
  - start is ignored outside IDLE.
- LOAD:
  - A serializer holds the current word plus bits_left.
  - wr_ready = (bits_left==0 || bits_left==1) and fewer than ceil(CHAIN_LENGTH/WORD_WIDTH) words accepted. This gives zero-bubble streaming between words.
  - chain_scan_en = (bits_left>0); chain_scan_in = serializer bit 0.
  - On each enabled edge: serializer shifts right, bits_left decrements, bit_count increments.
  - If wr_valid is low with the serializer empty: chain_scan_en=0 and the chain holds.
  - Final partial word: shifting stops at bit_count==CHAIN_LENGTH; unused upper bits are discarded and bits_left is forced to 0.
  - Example: word accepted at edge N -> its bit 0 enters the chain at edge N+1.
- READ:
  - chain_scan_in = chain_scan_out (recirculation).
  - chain_scan_en = (bit_count<CHAIN_LENGTH) and the collector is not stalled.
  - The collector captures chain_scan_out into bit position k of the current word.
  - When WORD_WIDTH bits are collected, or the final chain bit is collected: the word moves to the rd_data register if rd_valid==0, or if rd_valid && rd_ready in that cycle. Otherwise the collector stalls, with chain_scan_en=0.
  - A partial last word is zero-padded in its upper bits.
  - rd_valid holds, with rd_data stable, until accepted.
- Counts:
  - bit_count saturates at CHAIN_LENGTH.
  - The chain always sees exactly CHAIN_LENGTH enabled edges per operation.

Decomposition:
- Shared package scan_cfg_pkg:
  - state encoding: IDLE, LOAD, READ, DONE;
  - mode constants MODE_LOAD=0, MODE_READ=1;
  - the words_needed function (ceil(CHAIN_LENGTH/WORD_WIDTH)).
- One sub-module, scan_word_serializer: parallel-load, LSB-first shift register with a bits_left counter, used for LOAD.
- The READ collector is simple enough to stay inline.

Test Plan:
- All tests use CHAIN_LENGTH=20, WORD_WIDTH=8 and a 20-bit bench model of the chain.
- Load words 0xA5, 0x3C, 0xFF streamed back-to-back -> 20 consecutive chain_scan_en cycles; chain holds {0xF,0x3C,0xA5}, i.e. 20'hF3CA5; 3 words accepted; done pulses once; busy falls the cycle after.
- Readback after the above -> rd_data sequence 0xA5, 0x3C, 0x0F (zero-padded); chain still 20'hF3CA5 afterwards.
- Load with wr_valid dropped for 5 cycles after the first word -> chain_scan_en low exactly 5 cycles; bit_count holds at 8; final chain contents identical to the first test.
- Readback with rd_ready held low for 10 cycles after the first rd_valid -> shifting stalls at bit_count=16; rd_data stays 0xA5; completes correctly after release.
- start pulsed during LOAD -> ignored. Assert rst at bit_count=9 -> all outputs 0 immediately; a new start in load mode performs a full 20-bit load.

Source files
------------

// File: rtl/scan_chain_programmer_pkg.sv
// Shared FSM encoding, mode constants and sizing helper for the scan-chain programmer.
package scan_cfg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_READ = 1'b1;

    // Number of host words that cover the whole chain (ceiling division).
    function automatic int unsigned words_needed(input int unsigned chain_len, input int unsigned word_w);
        return (chain_len + word_w - 32'd1) / word_w;
    endfunction

endpackage

// File: rtl/scan_chain_programmer_if.sv
// Host-side request, write-word and read-word handshakes of the scan-chain programmer.
interface scan_chain_programmer_if #(parameter int WORD_WIDTH = 8) ();
    import scan_cfg_pkg::*;

    logic                  start;
    logic                  mode;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    modport master (
        output start, mode, wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  start, mode, wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/scan_chain_programmer_serializer.sv
// Parallel-load, LSB-first word serializer with a count of bits still to shift.
module scan_word_serializer #(
    parameter  int WORD_WIDTH = 8,
    localparam int BL_W       = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic                  shift_i,
    input  logic                  flush_i,
    output logic                  bit_o,
    output logic [BL_W-1:0]       bits_left_o
);

    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [BL_W-1:0]       bits_left_q, bits_left_d;

    // Next-state: a load overrides a simultaneous shift of the old word's last bit.
    always_comb begin
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        if (clear_i) begin
            shreg_d     = '0;
            bits_left_d = '0;
        end else if (load_i) begin
            shreg_d     = data_i;
            bits_left_d = BL_W'(WORD_WIDTH);
        end else if (shift_i) begin
            shreg_d     = {1'b0, shreg_q[WORD_WIDTH-1:1]};
            bits_left_d = flush_i ? '0 : (bits_left_q - BL_W'(1));
        end else begin
            shreg_d     = shreg_q;
            bits_left_d = bits_left_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q     <= '0;
            bits_left_q <= '0;
        end else begin
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
        end
    end

    assign bit_o       = shreg_q[0];
    assign bits_left_o = bits_left_q;

endmodule

// File: rtl/scan_chain_programmer.sv
// Loads or non-destructively reads back the fabric configuration scan chain from host words.
module scan_chain_programmer
    import scan_cfg_pkg::*;
#(
    parameter  int CHAIN_LENGTH = 64,
    parameter  int WORD_WIDTH   = 8,
    localparam int CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                      scan_clk,
    input  logic                      rst,
    scan_chain_programmer_if.slave    host,
    output logic                      chain_scan_en,
    output logic                      chain_scan_in,
    input  logic                      chain_scan_out,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          bit_count
);

    localparam int WORDS = words_needed(CHAIN_LENGTH, WORD_WIDTH);
    localparam int WA_W  = $clog2(WORDS + 1);
    localparam int CC_W  = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LENGTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LENGTH - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WA_W-1:0]       words_q, words_d;
    logic [WORD_WIDTH-1:0] col_q, col_d;
    logic [CC_W-1:0]       col_cnt_q, col_cnt_d;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic            ser_clear_s, ser_bit_s;
    logic [CC_W-1:0] ser_left_s;
    logic            load_en_s, read_en_s, wr_ready_s, wr_fire_s;
    logic            col_full_s, can_move_s, move_s, scan_in_s;

    scan_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
        .clk_i       (scan_clk),
        .rst_i       (rst),
        .clear_i     (ser_clear_s),
        .load_i      (wr_fire_s),
        .data_i      (host.wr_data),
        .shift_i     (load_en_s),
        .flush_i     (bit_cnt_q == LAST_CNT),
        .bit_o       (ser_bit_s),
        .bits_left_o (ser_left_s)
    );

    // Shift enables and handshakes; readback stalls only when a full word has nowhere to go.
    always_comb begin
        load_en_s  = (state_q == ST_LOAD) && (ser_left_s != '0);
        wr_ready_s = (state_q == ST_LOAD) && (ser_left_s <= CC_W'(1)) && (words_q < WA_W'(WORDS));
        wr_fire_s  = wr_ready_s && host.wr_valid;
        col_full_s = (col_cnt_q == CC_W'(WORD_WIDTH)) ||
                     ((bit_cnt_q == FULL_CNT) && (col_cnt_q != '0));
        can_move_s = !rd_valid_q || host.rd_ready;
        move_s     = (state_q == ST_READ) && col_full_s && can_move_s;
        read_en_s  = (state_q == ST_READ) && (bit_cnt_q < FULL_CNT) && !(col_full_s && !can_move_s);
        scan_in_s  = 1'b0;
        case (state_q)
            ST_LOAD: scan_in_s = ser_bit_s;
            ST_READ: scan_in_s = chain_scan_out;
            default: scan_in_s = 1'b0;
        endcase
    end

    // Next-state for FSM, counters, collector and read-word register.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        words_d     = words_q;
        col_d       = col_q;
        col_cnt_d   = col_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        ser_clear_s = 1'b0;

        if ((load_en_s || read_en_s) && (bit_cnt_q < FULL_CNT)) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
        if (wr_fire_s) begin
            words_d = words_q + WA_W'(1);
        end else begin
            words_d = words_q;
        end

        if (move_s) begin
            rd_data_d  = col_q;
            rd_valid_d = 1'b1;
            col_d      = '0;
            col_cnt_d  = '0;
        end else if (rd_valid_q && host.rd_ready) begin
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
        end
        // Capture lands in the freshly emptied collector when a move happens on the same edge.
        if (read_en_s) begin
            col_d     = col_d | (WORD_WIDTH'(chain_scan_out) << col_cnt_d);
            col_cnt_d = col_cnt_d + CC_W'(1);
        end else begin
            col_cnt_d = col_cnt_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    state_d     = (host.mode == MODE_READ) ? ST_READ : ST_LOAD;
                    bit_cnt_d   = '0;
                    words_d     = '0;
                    col_d       = '0;
                    col_cnt_d   = '0;
                    ser_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bit_cnt_q == FULL_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_READ: begin
                if ((bit_cnt_q == FULL_CNT) && (col_cnt_q == '0) && can_move_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge scan_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            words_q    <= '0;
            col_q      <= '0;
            col_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            words_q    <= words_d;
            col_q      <= col_d;
            col_cnt_q  <= col_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign chain_scan_en = load_en_s || read_en_s;
    assign chain_scan_in = scan_in_s;
    assign host.wr_ready = wr_ready_s;
    assign host.rd_data  = rd_data_q;
    assign host.rd_valid = rd_valid_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign bit_count     = bit_cnt_q;

endmodule

// File: tb/tb_scan_chain_programmer.sv
// Directed and randomized bench for scan_chain_programmer against a 20-bit chain model.
module tb_scan_chain_programmer;

    localparam int CL    = 20;
    localparam int WW    = 8;
    localparam int NW    = 3;
    localparam int CNT_W = $clog2(CL + 1);

    logic             scan_clk = 1'b0;
    logic             rst;
    logic             chain_scan_en, chain_scan_in, chain_scan_out, busy, done;
    logic [CNT_W-1:0] bit_count;
    logic [CL-1:0]    chain_m = '0;

    int checks   = 0;
    int failures = 0;
    int en_cycles, gap_cycles, run, max_run, done_pulses;
    bit seen_en;

    scan_chain_programmer_if #(.WORD_WIDTH(WW)) host ();

    scan_chain_programmer #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) dut (
        .scan_clk       (scan_clk),
        .rst            (rst),
        .host           (host),
        .chain_scan_en  (chain_scan_en),
        .chain_scan_in  (chain_scan_in),
        .chain_scan_out (chain_scan_out),
        .busy           (busy),
        .done           (done),
        .bit_count      (bit_count)
    );

    always #5 scan_clk = ~scan_clk;

    // Fabric chain: head at the top bit, tail drives scan_out.
    assign chain_scan_out = chain_m[0];
    always @(posedge scan_clk) if (chain_scan_en) chain_m <= {chain_scan_in, chain_m[CL-1:1]};

    // Per-operation activity statistics, cleared by an accepted start.
    always begin
        @(negedge scan_clk);
        #1;
        if (host.start && !busy) begin
            en_cycles <= 0; gap_cycles <= 0; run <= 0; max_run <= 0; done_pulses <= 0; seen_en <= 1'b0;
        end else begin
            if (chain_scan_en) begin
                en_cycles <= en_cycles + 1;
                run       <= run + 1;
                if (run + 1 > max_run) max_run <= run + 1;
                seen_en   <= 1'b1;
            end else begin
                run <= 0;
                if (seen_en && busy && int'(bit_count) < CL) gap_cycles <= gap_cycles + 1;
            end
            if (done) done_pulses <= done_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: word i bit b occupies chain position i*WW+b, position 0 being the tail.
    function automatic logic [CL-1:0] model_chain(input logic [NW-1:0][WW-1:0] w);
        logic [CL-1:0] c;
        c = '0;
        for (int i = 0; i < CL; i++) c[i] = w[i / WW][i % WW];
        return c;
    endfunction

    function automatic logic [WW-1:0] model_word(input logic [CL-1:0] c, input int k);
        logic [WW-1:0] r;
        r = '0;
        for (int b = 0; b < WW; b++) if (k * WW + b < CL) r[b] = c[k * WW + b];
        return r;
    endfunction

    task automatic do_load(input logic [NW-1:0][WW-1:0] w, input bit gap5, input bit rand_idle, input bit poke);
        int n;
        @(negedge scan_clk); host.start = 1'b1; host.mode = 1'b0;
        @(negedge scan_clk); host.start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (rand_idle) repeat ($urandom_range(0, 3)) @(negedge scan_clk);
            if (poke && i == 1) begin
                host.start = 1'b1; host.mode = 1'b1;
                @(negedge scan_clk); host.start = 1'b0; host.mode = 1'b0;
                check("poke_busy", busy, 32'd1);
                check("poke_en", chain_scan_en, 32'd1);
            end
            host.wr_data = w[i]; host.wr_valid = 1'b1;
            n = 0;
            while (!host.wr_ready && n < 100) begin @(negedge scan_clk); n++; end
            check("wr_ready_wait", n < 100, 32'd1);
            @(negedge scan_clk);
            host.wr_valid = 1'b0;
            if (gap5 && i == 0) begin
                n = 0;
                while (int'(bit_count) != 8 && n < 50) begin @(negedge scan_clk); n++; end
                check("gap_reach8", bit_count, 32'd8);
                repeat (4) begin
                    @(negedge scan_clk);
                    check("gap_hold8", bit_count, 32'd8);
                end
            end
        end
        n = 0;
        while (!done && n < 100) begin @(negedge scan_clk); n++; end
        check("load_done", done, 32'd1);
        check("load_busy_at_done", busy, 32'd1);
        check("load_wr_ready_end", host.wr_ready, 32'd0);
        @(negedge scan_clk);
        check("load_busy_after", busy, 32'd0);
        check("load_done_after", done, 32'd0);
        check("load_done_pulses", done_pulses, 32'd1);
        check("load_en_cycles", en_cycles, 32'(CL));
        check("load_chain", chain_m, model_chain(w));
    endtask

    task automatic do_read(input int stall_lo, input bit rand_ready, input logic [WW-1:0] first_exp,
                           input int stall_bc, output logic [NW-1:0][WW-1:0] got, output int ngot);
        int n, lo;
        bit seen;
        got = '0; ngot = 0; lo = 0; seen = 1'b0;
        @(negedge scan_clk); host.start = 1'b1; host.mode = 1'b1; host.rd_ready = 1'b1;
        @(negedge scan_clk); host.start = 1'b0; host.mode = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            if (host.rd_valid) seen = 1'b1;
            if (rand_ready) host.rd_ready = 1'($urandom_range(0, 1));
            else if (seen && lo < stall_lo) begin host.rd_ready = 1'b0; lo++; end
            else host.rd_ready = 1'b1;
            #1;
            if (!rand_ready && !host.rd_ready && lo > 0) begin
                check("stall_rd_data", host.rd_data, 32'(first_exp));
                if (lo == stall_lo) begin
                    check("stall_bit_count", bit_count, 32'(stall_bc));
                    check("stall_en_low", chain_scan_en, 32'd0);
                end
            end
            if (host.rd_valid && host.rd_ready) begin
                if (ngot < NW) got[ngot] = host.rd_data;
                ngot++;
            end
            @(negedge scan_clk); n++;
        end
        check("read_done", done, 32'd1);
        host.rd_ready = 1'b0;
        @(negedge scan_clk);
        check("read_busy_after", busy, 32'd0);
        check("read_en_cycles", en_cycles, 32'(CL));
        check("read_done_pulses", done_pulses, 32'd1);
    endtask

    task automatic verify_read(input logic [CL-1:0] exp_c, input logic [NW-1:0][WW-1:0] got, input int ngot);
        check("read_word_count", ngot, 32'(NW));
        for (int k = 0; k < NW; k++) check("read_word", got[k], 32'(model_word(exp_c, k)));
        check("read_chain_kept", chain_m, exp_c);
    endtask

    initial begin
        logic [NW-1:0][WW-1:0] wv, got;
        logic [CL-1:0]         exp_c;
        int                    ngot, n;

        host.start = 1'b0; host.mode = 1'b0; host.wr_data = '0; host.wr_valid = 1'b0; host.rd_ready = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_en", chain_scan_en, 32'd0);
        check("rst_wr_ready", host.wr_ready, 32'd0);
        check("rst_rd_valid", host.rd_valid, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_bit_count", bit_count, 32'd0);
        check("rst_rd_data", host.rd_data, 32'd0);
        @(negedge scan_clk); rst = 1'b0;

        // Back-to-back load of A5, 3C, FF.
        wv = {8'hFF, 8'h3C, 8'hA5};
        do_load(wv, 1'b0, 1'b0, 1'b0);
        check("t1_chain_const", chain_m, 32'h000F3CA5);
        check("t1_max_run", max_run, 32'(CL));
        check("t1_gap", gap_cycles, 32'd0);

        // Readback keeps the chain and returns zero-padded words.
        do_read(0, 1'b0, 8'h00, 0, got, ngot);
        verify_read(20'hF3CA5, got, ngot);
        check("t2_last_word_const", got[2], 32'h0000000F);

        // Randomized words with throttled valid/ready.
        for (int it = 0; it < 3; it++) begin
            wv = {8'($urandom), 8'($urandom), 8'($urandom)};
            exp_c = model_chain(wv);
            do_load(wv, 1'b0, 1'b1, 1'b0);
            do_read(0, 1'b1, 8'h00, 0, got, ngot);
            verify_read(exp_c, got, ngot);
        end

        // Load with wr_valid withheld for five cycles after the first word.
        wv = {8'hFF, 8'h3C, 8'hA5};
        do_load(wv, 1'b1, 1'b0, 1'b0);
        check("t3_gap", gap_cycles, 32'd5);
        check("t3_chain_const", chain_m, 32'h000F3CA5);

        // Readback with rd_ready held low for ten cycles after the first word appears.
        do_read(10, 1'b0, 8'hA5, 16, got, ngot);
        verify_read(20'hF3CA5, got, ngot);

        // Start pulsed mid-load is ignored.
        wv = {8'($urandom), 8'($urandom), 8'($urandom)};
        do_load(wv, 1'b0, 1'b0, 1'b1);

        // Reset mid-load at bit_count 9, then a complete reload.
        wv = {8'($urandom), 8'($urandom), 8'($urandom)};
        @(negedge scan_clk); host.start = 1'b1; host.mode = 1'b0;
        @(negedge scan_clk); host.start = 1'b0;
        host.wr_data = wv[0]; host.wr_valid = 1'b1;
        n = 0;
        while (!host.wr_ready && n < 50) begin @(negedge scan_clk); n++; end
        @(negedge scan_clk); host.wr_data = wv[1];
        n = 0;
        while (int'(bit_count) != 9 && n < 50) begin @(negedge scan_clk); n++; end
        check("rst_mid_reach9", bit_count, 32'd9);
        rst = 1'b1;
        #1;
        check("rst_mid_en", chain_scan_en, 32'd0);
        check("rst_mid_wr_ready", host.wr_ready, 32'd0);
        check("rst_mid_rd_valid", host.rd_valid, 32'd0);
        check("rst_mid_done", done, 32'd0);
        check("rst_mid_busy", busy, 32'd0);
        check("rst_mid_bit_count", bit_count, 32'd0);
        check("rst_mid_rd_data", host.rd_data, 32'd0);
        @(negedge scan_clk); rst = 1'b0; host.wr_valid = 1'b0;
        wv = {8'($urandom), 8'($urandom), 8'($urandom)};
        do_load(wv, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
